start_logo_addr_gen: RTL

//  Upstream address/compositing stage for the start-screen logo ROM (18-bit read_address -> 12-bit palette color).

---
 rtl/start_logo_addr_gen_if.sv | 23 ++
 rtl/start_logo_addr_gen.sv | 103 ++++++++++
 2 files changed

// File: rtl/start_logo_addr_gen_if.sv
// Beam-position / logo-ROM bundle between the VGA timing side and the logo address stage.
interface start_logo_addr_gen_if #(
  parameter int ADDR_W = 18
);
  logic              pixel_en;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              show_logo;
  logic [11:0]       rom_color;
  logic [ADDR_W-1:0] read_address;
  logic              logo_on;
  logic [11:0]       logo_color;

  modport master (
    output pixel_en, DrawX, DrawY, show_logo, rom_color,
    input  read_address, logo_on, logo_color
  );

  modport slave (
    input  pixel_en, DrawX, DrawY, show_logo, rom_color,
    output read_address, logo_on, logo_color
  );
endinterface

// File: rtl/start_logo_addr_gen.sv
// Start-screen logo address generator: beam position -> ROM address, then registered
// color and opaque flag two Clk later, with logo enable changes aligned to frame start.
module start_logo_addr_gen #(
  parameter int          LOGO_X0   = 144,
  parameter int          LOGO_Y0   = 40,
  parameter int          LOGO_W    = 352,
  parameter int          LOGO_H    = 176,
  parameter logic [11:0] KEY_COLOR = 12'h808,
  parameter int          ADDR_W    = 18
) (
  input  logic Clk,
  input  logic Reset_n,
  start_logo_addr_gen_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [9:0]        X_MIN   = 10'(LOGO_X0);
  localparam logic [9:0]        X_MAX   = 10'(LOGO_X0 + LOGO_W - 1);
  localparam logic [9:0]        Y_MIN   = 10'(LOGO_Y0);
  localparam logic [9:0]        Y_MAX   = 10'(LOGO_Y0 + LOGO_H - 1);
  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(LOGO_W);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              frame_start;
  logic              in_box;
  logic              draw;
  logic [9:0]        x_off;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_next;
  logic              in_box_d1;
  logic              draw_d1;

  assign frame_start = bus.pixel_en && (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
  assign in_box      = (bus.DrawX >= X_MIN) && (bus.DrawX <= X_MAX) &&
                       (bus.DrawY >= Y_MIN) && (bus.DrawY <= Y_MAX);
  assign draw        = (state == S_ACTIVE) || (state == S_DRAIN);
  assign x_off       = bus.DrawX - X_MIN;
  assign addr_next   = in_box ? (row_base + ADDR_W'(x_off)) : '0;

  // Enable changes only land on a frame boundary; DRAIN lets a dropped request finish the frame.
  always_comb begin
    state_next = state;
    if (bus.pixel_en) begin
      case (state)
        S_IDLE:   if (bus.show_logo) state_next = S_ARMED;
        S_ARMED:  if (!bus.show_logo) state_next = S_IDLE;
                  else if (frame_start) state_next = S_ACTIVE;
        S_ACTIVE: if (!bus.show_logo) state_next = S_DRAIN;
        S_DRAIN:  if (bus.show_logo) state_next = S_ACTIVE;
                  else if (frame_start) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Row base steps by one logo line on the strobe of each row's last column, replacing y*W.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_base <= '0;
    end else if (frame_start) begin
      row_base <= '0;
    end else if (bus.pixel_en && in_box && (bus.DrawX == X_MAX)) begin
      row_base <= row_base + ROW_INC;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.read_address <= '0;
      in_box_d1        <= 1'b0;
      draw_d1          <= 1'b0;
    end else begin
      bus.read_address <= addr_next;
      in_box_d1        <= in_box;
      draw_d1          <= draw;
    end
  end

  // rom_color answers the address registered last Clk, so it lines up with the d1 flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.logo_color <= 12'h000;
      bus.logo_on    <= 1'b0;
    end else begin
      bus.logo_color <= bus.rom_color;
      bus.logo_on    <= in_box_d1 && draw_d1 && (bus.rom_color != KEY_COLOR);
    end
  end

endmodule
